// File: rtl/codec_pkg.sv
// Shared constants for the CS4272 I2S transmit path.
package codec_pkg;

  localparam int CNT_W = 10;
  localparam int MCLK_BIT = 1;
  localparam int SCLK_BIT = 3;
  localparam int LRCLK_BIT = 9;
  localparam int SLOT_W = LRCLK_BIT - SCLK_BIT - 1;
  localparam int SLOT_BITS_DEF = 24;

  localparam logic [SLOT_W-1:0] FIRST_SLOT = 5'd1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 5'(SLOT_BITS_DEF);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [SLOT_W-1:0] slot_t;

endpackage

// File: rtl/codec_clk_gen.sv
// Free-running frame counter; codec clocks come straight off its flops.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output cnt_t cnt,
  output logic mclk,
  output logic sclk,
  output logic lrclk,
  output logic frm_strt,
  output logic adv,
  output logic wrap
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      frm_strt <= 1'b0;
    end else begin
      cnt      <= cnt + 1'b1;
      frm_strt <= wrap;
    end
  end

  assign mclk  = cnt[MCLK_BIT];
  assign sclk  = cnt[SCLK_BIT];
  assign lrclk = cnt[LRCLK_BIT];
  assign adv   = &cnt[SCLK_BIT:0];
  assign wrap  = &cnt;

endmodule

// File: rtl/codec_tx.sv
// I2S transmitter toward the CS4272: handshake, frame registers, serializer.
// Build option: CODEC_TX_MUTE_ON_UNDERRUN_EN silences frames on underrun.
module codec_tx
  import codec_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] lft_in,
  input  logic [SAMPLE_W-1:0] rht_in,
  input  logic                smpl_vld,
  output logic                smpl_rdy,
  output logic                MCLK,
  output logic                SCLK,
  output logic                LRCLK,
  output logic                SDin,
  output logic                frm_strt,
  output logic                underrun
);

  localparam int PAD = SLOT_BITS - SAMPLE_W;
  localparam slot_t LAST = slot_t'(SLOT_BITS);

  cnt_t cnt;
  cnt_t cnt_nxt;
  logic adv;
  logic wrap;

  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic [SAMPLE_W-1:0] frm_l, frm_r;
  logic                hold_full;
  logic                accept;

  logic [SLOT_BITS-1:0] slot_l, slot_r, word, word_sh;
  slot_t slot_nxt;
  logic  half_nxt;
  logic  bit_nxt;

  codec_clk_gen u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .mclk     (MCLK),
    .sclk     (SCLK),
    .lrclk    (LRCLK),
    .frm_strt (frm_strt),
    .adv      (adv),
    .wrap     (wrap)
  );

  assign smpl_rdy = ~hold_full;
  assign accept   = smpl_vld & ~hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l    <= '0;
      hold_r    <= '0;
      hold_full <= 1'b0;
      frm_l     <= '0;
      frm_r     <= '0;
      underrun  <= 1'b0;
    end else begin
      underrun <= wrap & ~hold_full;
      if (wrap) begin
        if (hold_full) begin
          frm_l     <= hold_l;
          frm_r     <= hold_r;
          hold_full <= 1'b0;
        end else begin
`ifdef CODEC_TX_MUTE_ON_UNDERRUN_EN
          frm_l <= '0;
          frm_r <= '0;
`else
          frm_l <= frm_l;
          frm_r <= frm_r;
`endif
        end
      end
      // A hold load on the wrap edge lands after the clear: next frame uses it.
      if (accept) begin
        hold_l    <= lft_in;
        hold_r    <= rht_in;
        hold_full <= 1'b1;
      end
    end
  end

  assign slot_l = SLOT_BITS'(frm_l) << PAD;
  assign slot_r = SLOT_BITS'(frm_r) << PAD;

  // Bit presented after this edge belongs to the slot the counter enters.
  assign cnt_nxt  = cnt + 1'b1;
  assign slot_nxt = cnt_nxt[LRCLK_BIT-1:SCLK_BIT+1];
  assign half_nxt = cnt_nxt[LRCLK_BIT];

  always_comb begin
    bit_nxt = 1'b0;
    word    = half_nxt ? slot_r : slot_l;
    word_sh = '0;
    if (slot_nxt >= FIRST_SLOT && slot_nxt <= LAST) begin
      word_sh = word << (slot_nxt - FIRST_SLOT);
      bit_nxt = word_sh[SLOT_BITS-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) SDin <= 1'b0;
    else if (adv) SDin <= bit_nxt;
  end

endmodule

// File: tb/tb_codec_tx.sv
// Directed bench for codec_tx: clocks, slot decode, handshake, underrun.
module tb_codec_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lft_in = '0;
  logic [15:0] rht_in = '0;
  logic        smpl_vld = 1'b0;
  logic        smpl_rdy, MCLK, SCLK, LRCLK, SDin, frm_strt, underrun;

  int checks = 0;
  int errors = 0;
  int tcnt = 0;

  codec_tx dut (
    .clk      (clk),
    .rst      (rst),
    .lft_in   (lft_in),
    .rht_in   (rht_in),
    .smpl_vld (smpl_vld),
    .smpl_rdy (smpl_rdy),
    .MCLK     (MCLK),
    .SCLK     (SCLK),
    .LRCLK    (LRCLK),
    .SDin     (SDin),
    .frm_strt (frm_strt),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt = (tcnt + 1) % 1024;
  endtask

  task automatic to_cnt(input int c);
    while (tcnt != c) tick();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    lft_in   = l;
    rht_in   = r;
    smpl_vld = 1'b1;
    checks++;
    if (smpl_rdy !== 1'b1) begin
      errors++;
      $display("FAIL push_rdy got %b want 1 at cnt %0d", smpl_rdy, tcnt);
    end
    tick();
    smpl_vld = 1'b0;
  endtask

  // Starts at cnt 0; records SDin at each SCLK rise for one frame.
  task automatic capture(output logic [23:0] l, output logic [23:0] r,
                         output logic [15:0] pad);
    logic [31:0] wl, wr;
    int b;
    wl = '0;
    wr = '0;
    for (int i = 0; i < 1024; i++) begin
      if (tcnt % 16 == 8) begin
        b = (tcnt / 16) % 32;
        if (tcnt < 512) wl[31-b] = SDin;
        else wr[31-b] = SDin;
      end
      tick();
    end
    l   = wl[30:7];
    r   = wr[30:7];
    pad = {wl[31], wl[6:0], wr[31], wr[6:0]};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst  = 1'b0;
    tcnt = 0;
    checks++;
    if ({MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, smpl_rdy} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_vals got %b want 0000001",
               {MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, smpl_rdy});
    end
  endtask

  task automatic test_clocks();
    logic [9:0] e;
    int first;
    int pulses;
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= 3000; i++) begin
      tick();
      e = tcnt[9:0];
      checks++;
      if ({MCLK, SCLK, LRCLK} !== {e[1], e[3], e[9]}) begin
        errors++;
        $display("FAIL clocks got %b want %b at cnt %0d",
                 {MCLK, SCLK, LRCLK}, {e[1], e[3], e[9]}, tcnt);
      end
      checks++;
      if ({frm_strt, underrun, SDin} !== {(e == 0), (e == 0), 1'b0}) begin
        errors++;
        $display("FAIL strobes got %b want %b at cnt %0d",
                 {frm_strt, underrun, SDin}, {(e == 0), (e == 0), 1'b0}, tcnt);
      end
      if (frm_strt === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    checks++;
    if (first !== 1024 || pulses !== 2) begin
      errors++;
      $display("FAIL frm_strt_first got %0d/%0d want 1024/2", first, pulses);
    end
  endtask

  task automatic test_data();
    logic [23:0] l, r;
    logic [15:0] pad;
    to_cnt(100);
    push(16'h8001, 16'h7FFE);
    checks++;
    if (smpl_rdy !== 1'b0) begin
      errors++;
      $display("FAIL data_rdy_low got %b want 0", smpl_rdy);
    end
    to_cnt(0);
    checks++;
    if ({frm_strt, underrun, smpl_rdy} !== 3'b101) begin
      errors++;
      $display("FAIL data_start got %b want 101", {frm_strt, underrun, smpl_rdy});
    end
    capture(l, r, pad);
    checks++;
    if (l !== 24'h800100 || r !== 24'h7FFE00) begin
      errors++;
      $display("FAIL data_slots got %h/%h want 800100/7ffe00", l, r);
    end
    checks++;
    if (pad !== 16'h0) begin
      errors++;
      $display("FAIL data_pad got %h want 0000", pad);
    end
  endtask

  task automatic test_underrun();
    logic [23:0] l, r, el, er;
    logic [15:0] pad;
    to_cnt(200);
    push(16'h1234, 16'h5678);
    to_cnt(0);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_none got %b want 0", underrun);
    end
    capture(l, r, pad);
    checks++;
    if (l !== 24'h123400 || r !== 24'h567800) begin
      errors++;
      $display("FAIL ur_ref got %h/%h want 123400/567800", l, r);
    end
    checks++;
    if ({frm_strt, underrun} !== 2'b11) begin
      errors++;
      $display("FAIL ur_pulse got %b want 11", {frm_strt, underrun});
    end
    tick();
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_width got %b want 0", underrun);
    end
    to_cnt(0);
`ifdef CODEC_TX_MUTE_ON_UNDERRUN_EN
    el = 24'h0;
    er = 24'h0;
`else
    el = 24'h123400;
    er = 24'h567800;
`endif
    capture(l, r, pad);
    checks++;
    if (l !== el || r !== er) begin
      errors++;
      $display("FAIL ur_policy got %h/%h want %h/%h", l, r, el, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] l, r;
    logic [15:0] pad;
    int acc;
    smpl_vld = 1'b1;
    for (int f = 0; f < 3; f++) begin
      lft_in = 16'hA000 | 16'(f);
      rht_in = 16'h5000 | 16'(f);
      acc = 0;
      if (f > 0) begin
        checks++;
        if (underrun !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ur got %b want 0 frame %0d", underrun, f);
        end
      end
      for (int i = 0; i < 1024; i++) begin
        if (tcnt == 0 || tcnt == 1 || tcnt == 512) begin
          checks++;
          if (smpl_rdy !== (tcnt == 0)) begin
            errors++;
            $display("FAIL b2b_rdy got %b want %b at cnt %0d", smpl_rdy, (tcnt == 0), tcnt);
          end
        end
        if (smpl_vld && smpl_rdy) acc++;
        tick();
      end
      checks++;
      if (acc !== 1) begin
        errors++;
        $display("FAIL b2b_accepts got %0d want 1 frame %0d", acc, f);
      end
    end
    smpl_vld = 1'b0;
    capture(l, r, pad);
    checks++;
    if (l !== 24'hA00200 || r !== 24'h500200) begin
      errors++;
      $display("FAIL b2b_data got %h/%h want a00200/500200", l, r);
    end
  endtask

  task automatic test_simul();
    logic [23:0] l, r, el, er;
    logic [15:0] pad;
    to_cnt(1023);
    push(16'h0F0F, 16'hF0F0);
    checks++;
    if ({frm_strt, underrun, smpl_rdy} !== 3'b110) begin
      errors++;
      $display("FAIL simul_start got %b want 110", {frm_strt, underrun, smpl_rdy});
    end
`ifdef CODEC_TX_MUTE_ON_UNDERRUN_EN
    el = 24'h0;
    er = 24'h0;
`else
    el = 24'hA00200;
    er = 24'h500200;
`endif
    capture(l, r, pad);
    checks++;
    if (l !== el || r !== er) begin
      errors++;
      $display("FAIL simul_cur got %h/%h want %h/%h", l, r, el, er);
    end
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL simul_next_ur got %b want 0", underrun);
    end
    capture(l, r, pad);
    checks++;
    if (l !== 24'h0F0F00 || r !== 24'hF0F000) begin
      errors++;
      $display("FAIL simul_next got %h/%h want 0f0f00/f0f000", l, r);
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] l, r;
    logic [15:0] pad;
    to_cnt(250);
    push(16'h4444, 16'h4444);
    to_cnt(300);
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    tcnt = 0;
    checks++;
    if ({MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, smpl_rdy} !== 7'b0000001) begin
      errors++;
      $display("FAIL rst_mid got %b want 0000001",
               {MCLK, SCLK, LRCLK, SDin, frm_strt, underrun, smpl_rdy});
    end
    for (int i = 1; i <= 1024; i++) begin
      tick();
      if (i == 1023 || i == 1024) begin
        checks++;
        if (frm_strt !== (i == 1024)) begin
          errors++;
          $display("FAIL rst_frm got %b want %b after %0d", frm_strt, (i == 1024), i);
        end
      end
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold_empty got %b want 1", underrun);
    end
    capture(l, r, pad);
    checks++;
    if (l !== 24'h0 || r !== 24'h0) begin
      errors++;
      $display("FAIL rst_frame got %h/%h want 000000/000000", l, r);
    end
  endtask

  initial begin
    test_reset();
    test_clocks();
    test_data();
    test_underrun();
    test_back_to_back();
    test_simul();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_tx.md
# codec_tx

Serial audio transmitter toward the CS4272 codec: generates MCLK/SCLK/LRCLK from the system clock and shifts processed left/right samples onto the codec's SDin pin in I2S format. Sits at the output end of the Equalizer datapath, mirroring the codec receive path that deserializes SDout. It accepts one stereo sample per frame through a valid/ready handshake and flags underruns.

## Interface
- SAMPLE_W, 16: input sample width, signed two's complement; must be ≤ 24.
- SLOT_BITS, 24: data bits per I2S channel slot; sample is left-justified, low bits zero-padded.
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- lft_in  in  SAMPLE_W  left sample.
- rht_in  in  SAMPLE_W  right sample.
- smpl_vld  in  1  lft_in/rht_in valid.
- smpl_rdy  out  1  holding register empty; transfer when smpl_vld & smpl_rdy.
- MCLK  out  1  codec master clock, clk/4.
- SCLK  out  1  serial bit clock, clk/16.
- LRCLK  out  1  frame clock, clk/1024 (48.828 kHz); low = left, high = right.
- SDin  out  1  serial data to codec.
- frm_strt  out  1  one-cycle pulse on the cycle the frame counter wraps to 0.
- underrun  out  1  one-cycle pulse when a frame starts with no held sample.

## Operation
- Free-running 10-bit counter cnt, +1 every clk, wraps 1023→0. MCLK = cnt[1], SCLK = cnt[3], LRCLK = cnt[9]; all driven straight from counter flops (glitch-free).
- Each LRCLK half = 32 SCLK periods; bit slot b = cnt[8:4].
- I2S one-bit delay: slot b=0 carries 0; b=1..24 carry slot bits 23..0 (MSB first); b=25..31 carry 0.
- SDin is a flop; it changes only on the clk edge where cnt[3:0] goes 15→0 (same edge SCLK falls), so the codec samples a stable bit on SCLK rise.
- Holding register (hold_l, hold_r, hold_full). smpl_rdy = ~hold_full. Handshake loads hold and sets hold_full.
- Frame start (edge where cnt goes 1023→0): if hold_full, copy hold into frame registers (frm_l, frm_r) and clear hold_full; otherwise pulse underrun and apply the underrun policy (see Configuration).
- Simultaneous handshake and frame start with hold empty: the new sample goes to hold and is used next frame; underrun still pulses for the current frame.
- Simultaneous handshake and frame start with hold full: cannot occur (smpl_rdy = 0).
- Left half serializes frm_l, right half frm_r; frame registers are stable for the whole frame.

## Timing
- Reset values: cnt=0, MCLK=0, SCLK=0, LRCLK=0, SDin=0, smpl_rdy=1, frm_strt=0, underrun=0, hold and frame registers 0.
- Reset mid-frame: everything returns to reset values on the next edge; the partial frame is abandoned and the holding register emptied.
- Latency from accepted sample to first data bit (slot b=1): worst case 1024 + 16 clk, best case 16 clk after the next frame start.
- frm_strt and underrun are asserted in the cycle cnt==0.
- Throughput: one stereo sample per 1024 clk.

## Configuration
- CODEC_TX_MUTE_ON_UNDERRUN_EN defined: on underrun, frame registers load 0 (silence).
- Undefined: on underrun, frame registers keep the previous frame (last sample repeated).
- underrun pulses in both builds.

## Structure
- Package codec_pkg: CNT_W=10, MCLK_BIT=1, SCLK_BIT=3, LRCLK_BIT=9, SLOT_BITS default, slot-index constants for the first and last data bits.
- Sub-module codec_clk_gen: counter plus MCLK/SCLK/LRCLK, frm_strt, and bit-advance strobe (cnt[3:0]==15). codec_tx holds the handshake, frame registers and serializer.

## Test plan
- Reset, then run 3000 clk -> MCLK period 4, SCLK period 16, LRCLK period 1024, 50% duty; first frm_strt at cnt wrap (cycle 1024).
- Push lft_in=16'h8001, rht_in=16'h7FFE before a frame -> decoded left slot 24'h800100, right slot 24'h7FFE00; SDin=0 at b=0 and b≥25.
- Hold smpl_vld high continuously -> exactly one acceptance per frame; smpl_rdy low from acceptance until the next frm_strt.
- No sample for a frame after 16'h1234 -> underrun pulse at cnt==0; with macro, slots all zero; without, 16'h1234 repeated.
- Handshake exactly on the frm_strt cycle with hold empty -> underrun pulses; the sample appears in the following frame.
- Assert rst at cnt=300 for 1 cycle -> all outputs at reset values next cycle; the next frm_strt follows 1024 cycles after reset deasserts.
